// File: rtl/rect_plot_pkg.sv
// Shared constants and types for the rectangle plot engine and its clients.
package rect_plot_pkg;

    // 3-bit VGA colour encoding {R, G, B}
    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;

    localparam int DEFAULT_SCREEN_W = 160;
    localparam int DEFAULT_SCREEN_H = 120;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to carry one rectangle request (x, y, w, h, colour, outline flag).
    function automatic int rect_req_width(input int x_w, input int y_w,
                                          input int dim_w, input int colour_w);
        return x_w + y_w + 2 * dim_w + colour_w + 1;
    endfunction

    localparam int RECT_REQ_W = rect_req_width(8, 8, 6, 3);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or after pointer.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  pointer,
    output logic [NUM_CH-1:0] grant
);

    logic [2*NUM_CH-1:0] req_dbl;
    logic [2*NUM_CH-1:0] gnt_dbl;
    logic [NUM_CH-1:0]   req_rot;
    logic [NUM_CH-1:0]   gnt_rot;

    // Rotate so the pointer channel sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        req_dbl = {req, req} >> pointer;
        req_rot = req_dbl[NUM_CH-1:0];
        gnt_rot = req_rot & (~req_rot + 1'b1);
        gnt_dbl = {gnt_rot, gnt_rot} << pointer;
        grant   = gnt_dbl[2*NUM_CH-1:NUM_CH];
    end

endmodule

// File: rtl/rect_plot_engine.sv
// Shared rectangle plot engine: arbitrates NUM_CH clients and emits one clipped pixel per clock.
// Optional outline drawing is enabled by defining RECT_OUTLINE_EN (adds port req_outline).
module rect_plot_engine
    import rect_plot_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int X_W      = 8,
    parameter int Y_W      = 8,
    parameter int DIM_W    = 6,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = DEFAULT_SCREEN_W,
    parameter int SCREEN_H = DEFAULT_SCREEN_H
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH*X_W-1:0]        req_x,
    input  logic [NUM_CH*Y_W-1:0]        req_y,
    input  logic [NUM_CH*DIM_W-1:0]      req_w,
    input  logic [NUM_CH*DIM_W-1:0]      req_h,
    input  logic [NUM_CH*COLOUR_W-1:0]   req_colour,
`ifdef RECT_OUTLINE_EN
    input  logic [NUM_CH-1:0]            req_outline,
`endif
    output logic [X_W-1:0]               plot_x,
    output logic [Y_W-1:0]               plot_y,
    output logic [COLOUR_W-1:0]          plot_colour,
    output logic                         plot,
    output logic                         busy,
    output logic [NUM_CH-1:0]            done
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CX_W  = X_W + 1;
    localparam int CY_W  = Y_W + 1;

    state_t              state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    owner;
    logic [X_W-1:0]      x0;
    logic [Y_W-1:0]      y0;
    logic [DIM_W-1:0]    w;
    logic [DIM_W-1:0]    h;
    logic [DIM_W-1:0]    col;
    logic [DIM_W-1:0]    row;
    logic [COLOUR_W-1:0] colour;
    logic                outline;

    logic [NUM_CH-1:0]   grant;
    logic                accept;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req     (req_valid),
        .pointer (rr_ptr),
        .grant   (grant)
    );

    assign accept    = (state == IDLE) && (|grant);
    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign busy      = (state != IDLE);

    // One-hot AND-OR mux of the granted channel's request fields
    logic [X_W-1:0]      m_x      [NUM_CH];
    logic [Y_W-1:0]      m_y      [NUM_CH];
    logic [DIM_W-1:0]    m_w      [NUM_CH];
    logic [DIM_W-1:0]    m_h      [NUM_CH];
    logic [COLOUR_W-1:0] m_colour [NUM_CH];
    logic [IDX_W-1:0]    m_idx    [NUM_CH];
    logic                m_ol     [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_field
        assign m_x[gi]      = req_x[gi*X_W +: X_W] & {X_W{grant[gi]}};
        assign m_y[gi]      = req_y[gi*Y_W +: Y_W] & {Y_W{grant[gi]}};
        assign m_w[gi]      = req_w[gi*DIM_W +: DIM_W] & {DIM_W{grant[gi]}};
        assign m_h[gi]      = req_h[gi*DIM_W +: DIM_W] & {DIM_W{grant[gi]}};
        assign m_colour[gi] = req_colour[gi*COLOUR_W +: COLOUR_W] & {COLOUR_W{grant[gi]}};
        assign m_idx[gi]    = grant[gi] ? IDX_W'(gi) : '0;
`ifdef RECT_OUTLINE_EN
        assign m_ol[gi]     = req_outline[gi] & grant[gi];
`else
        assign m_ol[gi]     = 1'b0;
`endif
    end

    logic [X_W-1:0]      sel_x;
    logic [Y_W-1:0]      sel_y;
    logic [DIM_W-1:0]    sel_w;
    logic [DIM_W-1:0]    sel_h;
    logic [COLOUR_W-1:0] sel_colour;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_outline;

    always_comb begin
        sel_x       = '0;
        sel_y       = '0;
        sel_w       = '0;
        sel_h       = '0;
        sel_colour  = '0;
        sel_idx     = '0;
        sel_outline = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_x       = sel_x | m_x[i];
            sel_y       = sel_y | m_y[i];
            sel_w       = sel_w | m_w[i];
            sel_h       = sel_h | m_h[i];
            sel_colour  = sel_colour | m_colour[i];
            sel_idx     = sel_idx | m_idx[i];
            sel_outline = sel_outline | m_ol[i];
        end
    end

    // Raster stepping relative to (x0, y0); outline interior rows jump from the left to the right edge.
    logic             last_col;
    logic             last_row;
    logic             interior_row;
    logic             pixel_last;
    logic [DIM_W-1:0] nxt_col;
    logic [DIM_W-1:0] nxt_row;

    always_comb begin
        last_col     = (col == w - DIM_W'(1));
        last_row     = (row == h - DIM_W'(1));
        interior_row = outline && (row != '0) && !last_row;
        pixel_last   = last_col && last_row;
        nxt_col      = col + DIM_W'(1);
        nxt_row      = row;
        if (last_col) begin
            nxt_col = '0;
            nxt_row = row + DIM_W'(1);
        end else if (interior_row && (col == '0)) begin
            nxt_col = w - DIM_W'(1);
        end
    end

    // Pixel to be emitted at the coming edge, widened by one bit so carry-out is clipped too
    logic                emit_en;
    logic [X_W-1:0]      emit_x0;
    logic [Y_W-1:0]      emit_y0;
    logic [DIM_W-1:0]    emit_col;
    logic [DIM_W-1:0]    emit_row;
    logic [COLOUR_W-1:0] emit_colour;
    logic [CX_W-1:0]     emit_cx;
    logic [CY_W-1:0]     emit_cy;
    logic                emit_vis;

    always_comb begin
        emit_en     = 1'b0;
        emit_x0     = x0;
        emit_y0     = y0;
        emit_col    = nxt_col;
        emit_row    = nxt_row;
        emit_colour = colour;
        if (state == IDLE) begin
            emit_en     = accept && (sel_w != '0) && (sel_h != '0);
            emit_x0     = sel_x;
            emit_y0     = sel_y;
            emit_col    = '0;
            emit_row    = '0;
            emit_colour = sel_colour;
        end else if (state == DRAW) begin
            emit_en = !pixel_last;
        end
        emit_cx  = {1'b0, emit_x0} + CX_W'(emit_col);
        emit_cy  = {1'b0, emit_y0} + CY_W'(emit_row);
        emit_vis = (emit_cx < CX_W'(SCREEN_W)) && (emit_cy < CY_W'(SCREEN_H));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            x0          <= '0;
            y0          <= '0;
            w           <= '0;
            h           <= '0;
            col         <= '0;
            row         <= '0;
            colour      <= '0;
            outline     <= 1'b0;
            plot_x      <= '0;
            plot_y      <= '0;
            plot_colour <= '0;
            plot        <= 1'b0;
            done        <= '0;
        end else begin
            done <= '0;
            plot <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        x0      <= sel_x;
                        y0      <= sel_y;
                        w       <= sel_w;
                        h       <= sel_h;
                        colour  <= sel_colour;
                        outline <= sel_outline;
                        owner   <= sel_idx;
                        col     <= '0;
                        row     <= '0;
                        rr_ptr  <= (sel_idx == IDX_W'(NUM_CH - 1)) ? '0 : sel_idx + IDX_W'(1);
                        if ((sel_w == '0) || (sel_h == '0)) begin
                            state <= DONE;
                            done  <= grant;
                        end else begin
                            state <= DRAW;
                        end
                    end
                end
                DRAW: begin
                    if (pixel_last) begin
                        state <= DONE;
                        done  <= NUM_CH'(1) << owner;
                    end else begin
                        col <= nxt_col;
                        row <= nxt_row;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (emit_en) begin
                plot <= emit_vis;
                if (emit_vis) begin
                    plot_x      <= emit_cx[X_W-1:0];
                    plot_y      <= emit_cy[Y_W-1:0];
                    plot_colour <= emit_colour;
                end
            end
        end
    end

endmodule

// File: tb/tb_rect_plot_engine.sv
// Self-checking bench for rect_plot_engine: per-cycle model comparison plus directed literal checks.
module tb_rect_plot_engine;

    localparam int NCH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    req_valid = '0;
    logic [NCH-1:0]    req_ready;
    logic [NCH*8-1:0]  req_x;
    logic [NCH*8-1:0]  req_y;
    logic [NCH*6-1:0]  req_w;
    logic [NCH*6-1:0]  req_h;
    logic [NCH*3-1:0]  req_colour;
`ifdef RECT_OUTLINE_EN
    logic [NCH-1:0]    req_outline;
`endif
    logic [7:0]        plot_x;
    logic [7:0]        plot_y;
    logic [2:0]        plot_colour;
    logic              plot;
    logic              busy;
    logic [NCH-1:0]    done;

    int fx[NCH];
    int fy[NCH];
    int fw[NCH];
    int fh[NCH];
    int fc[NCH];
    int fo[NCH];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_drive
        assign req_x[gi*8 +: 8]      = 8'(fx[gi]);
        assign req_y[gi*8 +: 8]      = 8'(fy[gi]);
        assign req_w[gi*6 +: 6]      = 6'(fw[gi]);
        assign req_h[gi*6 +: 6]      = 6'(fh[gi]);
        assign req_colour[gi*3 +: 3] = 3'(fc[gi]);
`ifdef RECT_OUTLINE_EN
        assign req_outline[gi]       = (fo[gi] != 0);
`endif
    end

    rect_plot_engine dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_w       (req_w),
        .req_h       (req_h),
        .req_colour  (req_colour),
`ifdef RECT_OUTLINE_EN
        .req_outline (req_outline),
`endif
        .plot_x      (plot_x),
        .plot_y      (plot_y),
        .plot_colour (plot_colour),
        .plot        (plot),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of what each future cycle must show
    typedef struct {
        bit plot;
        int x;
        int y;
        int colour;
        int done_ch;
    } ent_t;

    ent_t exp_q[$];
    int   m_ptr = 0;
    int   grant_log[$];

    function automatic int model_grant();
        for (int k = 0; k < NCH; k++) begin
            if (req_valid[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
        end
        return -1;
    endfunction

    function automatic void build_rect(input int g);
        ent_t e;
        for (int r = 0; r < fh[g]; r++) begin
            for (int c = 0; c < fw[g]; c++) begin
                if (fo[g] != 0 && r > 0 && r < fh[g] - 1 && c > 0 && c < fw[g] - 1) continue;
                e.x       = fx[g] + c;
                e.y       = fy[g] + r;
                e.plot    = (e.x < 160) && (e.y < 120);
                e.colour  = fc[g];
                e.done_ch = -1;
                exp_q.push_back(e);
            end
        end
        e.plot    = 1'b0;
        e.x       = 0;
        e.y       = 0;
        e.colour  = 0;
        e.done_ch = g;
        exp_q.push_back(e);
    endfunction

    // Observed statistics used by the directed literal checks
    int cyc = 0;
    int plot_cnt, draw_cnt, ready_cnt, multi_done, idle_between, interior_hits;
    int first_x, first_y, last_x, last_y, done_cyc, accept_cyc;
    int int_x0, int_x1, int_y0, int_y1;
    int done_log[$];

    task automatic clear_stats();
        plot_cnt = 0; draw_cnt = 0; ready_cnt = 0; multi_done = 0;
        idle_between = 0; interior_hits = 0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        done_cyc = -1; accept_cyc = -1;
        int_x0 = -1; int_x1 = -2; int_y0 = -1; int_y1 = -2;
        done_log.delete();
        grant_log.delete();
    endtask

    ent_t e_cur;
    int   g_cur;
    int   d_idx;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            m_ptr = 0;
            check("rst_plot", 32'(plot), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_done", 32'(done), 0);
            check("rst_ready", 32'(req_ready), 0);
        end else if (exp_q.size() > 0) begin
            e_cur = exp_q.pop_front();
            check("plot", 32'(plot), 32'(e_cur.plot));
            check("busy", 32'(busy), 1);
            check("done", 32'(done), (e_cur.done_ch >= 0) ? (32'd1 << e_cur.done_ch) : 32'd0);
            check("ready_busy", 32'(req_ready), 0);
            if (e_cur.plot) begin
                check("plot_x", 32'(plot_x), e_cur.x);
                check("plot_y", 32'(plot_y), e_cur.y);
                check("plot_colour", 32'(plot_colour), e_cur.colour);
            end
        end else begin
            check("idle_busy", 32'(busy), 0);
            check("idle_plot", 32'(plot), 0);
            check("idle_done", 32'(done), 0);
            g_cur = model_grant();
            check("ready", 32'(req_ready), (g_cur >= 0) ? (32'd1 << g_cur) : 32'd0);
            if (g_cur >= 0) begin
                build_rect(g_cur);
                m_ptr = (g_cur + 1) % NCH;
                grant_log.push_back(g_cur);
            end
        end

        if (!rst) begin
            if (req_ready != '0) ready_cnt++;
            if (!busy && done_log.size() >= 1 && done_log.size() < 5) idle_between++;
            if (busy && done == '0) draw_cnt++;
            if (plot) begin
                plot_cnt++;
                if (first_x < 0) begin
                    first_x = int'(plot_x);
                    first_y = int'(plot_y);
                end
                last_x = int'(plot_x);
                last_y = int'(plot_y);
                if (int'(plot_x) >= int_x0 && int'(plot_x) <= int_x1 &&
                    int'(plot_y) >= int_y0 && int'(plot_y) <= int_y1) interior_hits++;
            end
            if (done != '0) begin
                if ($countones(done) > 1) multi_done++;
                d_idx = -1;
                for (int i = 0; i < NCH; i++) if (done[i]) d_idx = i;
                done_log.push_back(d_idx);
                done_cyc = cyc;
                $display("txn: ch%0d rectangle complete at cycle %0d", d_idx, cyc);
            end
        end
    end

    task automatic set_fields(input int ch, input int x, input int y, input int w,
                              input int h, input int c, input int o);
        fx[ch] = x; fy[ch] = y; fw[ch] = w; fh[ch] = h; fc[ch] = c; fo[ch] = o;
    endtask

    task automatic send(input int ch, input int x, input int y, input int w,
                        input int h, input int c, input int o);
        bit ok;
        @(posedge clk); #1;
        clear_stats();
        set_fields(ch, x, y, w, h, c, o);
        req_valid[ch] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #1;
            if (req_ready[ch]) begin
                ok = 1'b1;
                accept_cyc = cyc;
                break;
            end
        end
        check("accept_timeout", 32'(ok), 1);
        @(posedge clk); #1;
        req_valid[ch] = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (!busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", 32'(ok), 1);
    endtask

    task automatic wait_dones(input int n, input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (done_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_timeout", 32'(ok), 1);
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) set_fields(i, 0, 0, 0, 0, 0, 0);
        clear_stats();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: single column, 16 pixels
        send(0, 10, 52, 1, 16, 1, 0);
        wait_idle(200);
        check("t1_plots", plot_cnt, 16);
        check("t1_first_x", first_x, 10);
        check("t1_first_y", first_y, 52);
        check("t1_last_x", last_x, 10);
        check("t1_last_y", last_y, 67);
        check("t1_done_ch", (done_log.size() == 1) ? done_log[0] : -1, 0);
        check("t1_latency", done_cyc - accept_cyc, 17);
        check("t1_ready_cycles", ready_cnt, 1);

        // 2: corner clipping
        send(1, 158, 118, 4, 4, 2, 0);
        wait_idle(200);
        check("t2_plots", plot_cnt, 4);
        check("t2_draw_cycles", draw_cnt, 16);
        check("t2_first", first_x * 1000 + first_y, 158118);
        check("t2_last", last_x * 1000 + last_y, 159119);
        check("t2_done_ch", (done_log.size() == 1) ? done_log[0] : -1, 1);
        check("t2_latency", done_cyc - accept_cyc, 17);

        // 3: all channels contend from reset
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < NCH; i++) set_fields(i, 20 * i, 5, 2, 3, i + 1, 0);
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_stats();
        wait_dones(5, 300);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle(200);
        check("t3_n_done", done_log.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check("t3_order", (done_log.size() > k) ? done_log[k] : -1, k % NCH);
            check("t3_model_order", (grant_log.size() > k) ? grant_log[k] : -1, k % NCH);
        end
        check("t3_multi_done", multi_done, 0);
        check("t3_idle_gaps", idle_between, 4);

        // 4: zero-width request completes immediately
        send(2, 30, 30, 0, 5, 3, 0);
        wait_idle(50);
        check("t4_plots", plot_cnt, 0);
        check("t4_draw_cycles", draw_cnt, 0);
        check("t4_done_ch", (done_log.size() == 1) ? done_log[0] : -1, 2);
        check("t4_latency", done_cyc - accept_cyc, 1);

        // Single row running off the right edge
        send(1, 150, 10, 20, 1, 4, 0);
        wait_idle(100);
        check("t4b_plots", plot_cnt, 10);
        check("t4b_draw_cycles", draw_cnt, 20);
        check("t4b_last_x", last_x, 159);

        // 5: reset in the middle of an 8x8 fill
        send(0, 40, 40, 8, 8, 5, 0);
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_plot_now", 32'(plot), 0);
        check("t5_busy_now", 32'(busy), 0);
        check("t5_done_now", 32'(done), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(3, 100, 100, 3, 2, 6, 0);
        wait_idle(100);
        check("t5_done_ch", (done_log.size() == 1) ? done_log[0] : -1, 3);
        check("t5_plots", plot_cnt, 6);

`ifdef RECT_OUTLINE_EN
        // 6: outlined rectangle skips its interior
        send(0, 20, 30, 5, 4, 1, 1);
        int_x0 = 21; int_x1 = 23; int_y0 = 31; int_y1 = 32;
        wait_idle(100);
        check("t6_plots", plot_cnt, 14);
        check("t6_draw_cycles", draw_cnt, 14);
        check("t6_interior", interior_hits, 0);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
